// File: rtl/i2c_regif.sv
`default_nettype none
// ------------------------------------------------------------------------
// i2c_regif : I2C target turning bus traffic into register strobes (rev 1.0)
// ------------------------------------------------------------------------
module i2c_regif #(
  parameter logic [6:0] I2C_ADDR = 7'h70
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sda_in,
  input  logic       scl_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] wr_data,
  output logic       wr_en,
  output logic       rd_req,
  input  logic [7:0] rd_data,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    DEVADDR = 4'd1,
    DEVACK  = 4'd2,
    SUBADDR = 4'd3,
    SUBACK  = 4'd4,
    WDATA   = 4'd5,
    WACK    = 4'd6,
    RDATA   = 4'd7,
    RACK    = 4'd8,
    IGNORE  = 4'd9
  } state_t;

  state_t     state;
  logic [2:0] sda_s, scl_s;
  logic [2:0] bit_cnt, nxt_bit;
  logic [6:0] rx;
  logic [7:0] tx, rx_byte;
  logic       rw, nack, rd_pend;
  logic       sda, scl_rise, scl_fall, start_det, stop_det;

  // Stage [1] is the synchronized value, stage [2] its one-cycle history.
  assign sda       = sda_s[1];
  assign scl_rise  =  scl_s[1] & ~scl_s[2];
  assign scl_fall  = ~scl_s[1] &  scl_s[2];
  assign start_det =  scl_s[1] &  scl_s[2] &  sda_s[2] & ~sda_s[1];
  assign stop_det  =  scl_s[1] &  scl_s[2] & ~sda_s[2] &  sda_s[1];
  assign rx_byte   = {rx, sda};
  assign nxt_bit   = bit_cnt - 3'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sda_s    <= 3'b111;
      scl_s    <= 3'b111;
      state    <= IDLE;
      bit_cnt  <= 3'd7;
      rx       <= 7'd0;
      tx       <= 8'd0;
      rw       <= 1'b0;
      nack     <= 1'b0;
      rd_pend  <= 1'b0;
      sda_oe   <= 1'b0;
      reg_addr <= 8'd0;
      wr_data  <= 8'd0;
      wr_en    <= 1'b0;
      rd_req   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      sda_s   <= {sda_s[1:0], sda_in};
      scl_s   <= {scl_s[1:0], scl_in};
      wr_en   <= 1'b0;
      rd_req  <= 1'b0;
      rd_pend <= rd_req;
      if (start_det) begin
        state   <= DEVADDR;
        bit_cnt <= 3'd7;
        sda_oe  <= 1'b0;
        busy    <= 1'b1;
      end else if (stop_det) begin
        state  <= IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          DEVADDR: if (scl_rise) begin
            rx <= rx_byte[6:0];
            if (bit_cnt == 3'd0) begin
              rw    <= rx_byte[0];
              state <= (rx_byte[7:1] == I2C_ADDR) ? DEVACK : IGNORE;
            end else begin
              bit_cnt <= nxt_bit;
            end
          end
          // ACK states: first fall asserts the ACK, the second (ninth) releases it.
          DEVACK: if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe <= 1'b1;
            end else begin
              sda_oe  <= 1'b0;
              bit_cnt <= 3'd7;
              rd_req  <= rw;
              state   <= rw ? RDATA : SUBADDR;
            end
          end
          SUBADDR: if (scl_rise) begin
            rx <= rx_byte[6:0];
            if (bit_cnt == 3'd0) begin
              reg_addr <= rx_byte;
              state    <= SUBACK;
            end else begin
              bit_cnt <= nxt_bit;
            end
          end
          SUBACK: if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe <= 1'b1;
            end else begin
              sda_oe  <= 1'b0;
              bit_cnt <= 3'd7;
              state   <= WDATA;
            end
          end
          WDATA: if (scl_rise) begin
            rx <= rx_byte[6:0];
            if (bit_cnt == 3'd0) begin
              wr_data <= rx_byte;
              wr_en   <= 1'b1;
              state   <= WACK;
            end else begin
              bit_cnt <= nxt_bit;
            end
          end
          WACK: if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe <= 1'b1;
            end else begin
              sda_oe   <= 1'b0;
              bit_cnt  <= 3'd7;
              reg_addr <= reg_addr + 8'd1;
              state    <= WDATA;
            end
          end
          // Bit 7 is presented as soon as the fetched byte arrives (SCL is still low).
          RDATA: if (rd_pend) begin
            tx     <= rd_data;
            sda_oe <= ~rd_data[7];
          end else if (scl_fall) begin
            if (bit_cnt == 3'd0) begin
              sda_oe <= 1'b0;
              state  <= RACK;
            end else begin
              sda_oe  <= ~tx[nxt_bit];
              bit_cnt <= nxt_bit;
            end
          end
          RACK: begin
            if (scl_rise) begin
              nack <= sda;
            end else if (scl_fall) begin
              if (!nack) begin
                reg_addr <= reg_addr + 8'd1;
                rd_req   <= 1'b1;
                bit_cnt  <= 3'd7;
                state    <= RDATA;
              end else begin
                state <= IGNORE;
              end
            end
          end
          IGNORE:  sda_oe <= 1'b0;
          IDLE:    sda_oe <= 1'b0;
          default: state  <= IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_regif.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_i2c_regif : bus-level scoreboard bench for i2c_regif (rev 1.0)
// ------------------------------------------------------------------------
module tb_i2c_regif;

  localparam int Q = 8;  // quarter SCL period in clk cycles

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sda_oe, wr_en, rd_req, busy;
  logic [7:0] reg_addr, wr_data;
  logic [7:0] rd_data = 8'd0;

  int n_checks = 0;
  int n_pass = 0;
  int oe_cnt = 0;

  logic [15:0] wq[$];
  logic [7:0]  rq[$];
  logic [7:0]  bq[$];
  logic [15:0] exp_w;
  logic [7:0]  exp_r;

  assign sda_line = sda_m & ~sda_oe;

  i2c_regif dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sda_in   (sda_line),
    .scl_in   (scl),
    .sda_oe   (sda_oe),
    .reg_addr (reg_addr),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .rd_req   (rd_req),
    .rd_data  (rd_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Register file model: one-cycle fetch latency, contents are addr ^ 0xA5.
  always @(posedge clk) if (rd_req) rd_data <= reg_addr ^ 8'hA5;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (sda_oe) oe_cnt++;
    if (rst_n && (wr_en || rd_req)) begin
      check("wr_rd_excl", 16'(wr_en & rd_req), 16'd0);
      if (wr_en) begin
        if (wq.size() == 0) check("wr_unexpected", 16'(wr_en), 16'd0);
        else begin
          exp_w = wq.pop_front();
          check("wr_addr_data", {reg_addr, wr_data}, exp_w);
        end
      end
      if (rd_req) begin
        if (rq.size() == 0) check("rd_unexpected", 16'(rd_req), 16'd0);
        else begin
          exp_r = rq.pop_front();
          check("rd_addr", 16'(reg_addr), 16'(exp_r));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tick(Q);
    scl = 1'b1;   tick(Q);
    sda_m = 1'b0; tick(Q);
    scl = 1'b0;   tick(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(Q);
    scl = 1'b1;   tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  task automatic wr_bit(input logic b);
    sda_m = b;  tick(Q);
    scl = 1'b1; tick(2 * Q);
    scl = 1'b0; tick(Q);
  endtask

  task automatic rd_bit(output logic b);
    sda_m = 1'b1; tick(Q);
    scl = 1'b1;   tick(Q);
    b = sda_line; tick(Q);
    scl = 1'b0;   tick(Q);
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) wr_bit(d[i]);
    rd_bit(b);
    ack = ~b;
  endtask

  task automatic rd_byte(input logic master_nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      rd_bit(b);
      d[i] = b;
    end
    wr_bit(master_nack);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic       ack;
    logic [7:0] d;
    int         base, k;

    tick(3);
    check("rst_sda_oe", 16'(sda_oe), 16'd0);
    check("rst_reg_addr", 16'(reg_addr), 16'd0);
    check("rst_wr_data", 16'(wr_data), 16'd0);
    check("rst_strobes", 16'({wr_en, rd_req}), 16'd0);
    check("rst_busy", 16'(busy), 16'd0);
    rst_n = 1'b1;
    tick(4);

    // Write with auto-increment
    wq.push_back({8'h0A, 8'h55});
    wq.push_back({8'h0B, 8'h1F});
    i2c_start();
    check("t1_busy", 16'(busy), 16'd1);
    wr_byte(8'hE0, ack); check("t1_ack_dev", 16'(ack), 16'd1);
    wr_byte(8'h0A, ack); check("t1_ack_sub", 16'(ack), 16'd1);
    wr_byte(8'h55, ack); check("t1_ack_d0", 16'(ack), 16'd1);
    wr_byte(8'h1F, ack); check("t1_ack_d1", 16'(ack), 16'd1);
    check("t1_ptr", 16'(reg_addr), 16'h0C);
    i2c_stop();
    tick(6);
    check("t1_busy_clr", 16'(busy), 16'd0);

    // Pointer wrap
    wq.push_back({8'hFF, 8'hFA});
    wq.push_back({8'h00, 8'h4D});
    i2c_start();
    wr_byte(8'hE0, ack); check("t2_ack_dev", 16'(ack), 16'd1);
    wr_byte(8'hFF, ack);
    wr_byte(8'hFA, ack);
    wr_byte(8'h4D, ack); check("t2_ack_d1", 16'(ack), 16'd1);
    check("t2_ptr_wrap", 16'(reg_addr), 16'h01);
    i2c_stop();

    // Read via repeated start, ACK then NACK
    i2c_start();
    wr_byte(8'hE0, ack);
    wr_byte(8'h7E, ack);
    rq.push_back(8'h7E);
    rq.push_back(8'h7F);
    bq.push_back(8'h7E ^ 8'hA5);
    bq.push_back(8'h7F ^ 8'hA5);
    i2c_start();
    wr_byte(8'hE1, ack); check("t3_ack_rd", 16'(ack), 16'd1);
    rd_byte(1'b0, d); check("t3_byte0", 16'(d), 16'(bq.pop_front()));
    rd_byte(1'b1, d); check("t3_byte1", 16'(d), 16'(bq.pop_front()));
    check("t3_ptr", 16'(reg_addr), 16'h7F);
    i2c_stop();
    tick(6);

    // Foreign address: no ACK, no strobes
    base = oe_cnt;
    i2c_start();
    wr_byte(8'hA0, ack); check("t4_no_ack", 16'(ack), 16'd0);
    wr_byte(8'h12, ack);
    wr_byte(8'h34, ack);
    check("t4_busy", 16'(busy), 16'd1);
    i2c_stop();
    tick(6);
    check("t4_busy_clr", 16'(busy), 16'd0);
    check("t4_no_oe", 16'(oe_cnt - base), 16'd0);

    // STOP after 4 data bits discards the byte; a following write succeeds
    i2c_start();
    wr_byte(8'hE0, ack);
    wr_byte(8'h10, ack);
    for (int i = 0; i < 4; i++) wr_bit(1'b1);
    i2c_stop();
    tick(6);
    check("t5_idle", 16'(busy), 16'd0);
    wq.push_back({8'h10, 8'h77});
    i2c_start();
    wr_byte(8'hE0, ack);
    wr_byte(8'h10, ack);
    wr_byte(8'h77, ack); check("t5_ack_full", 16'(ack), 16'd1);
    i2c_stop();
    tick(6);

    // Asynchronous reset while the target drives SDA during a read
    i2c_start();
    wr_byte(8'hE0, ack);
    wr_byte(8'hA0, ack);
    rq.push_back(8'hA0);
    i2c_start();
    wr_byte(8'hE1, ack);
    sda_m = 1'b1;
    k = 0;
    while (!sda_oe && k < 40) begin
      tick(1);
      k++;
    end
    check("t6_pre_oe", 16'(sda_oe), 16'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_oe", 16'(sda_oe), 16'd0);
    check("t6_reg_addr", 16'(reg_addr), 16'd0);
    check("t6_wr_data", 16'(wr_data), 16'd0);
    check("t6_strobes", 16'({wr_en, rd_req}), 16'd0);
    check("t6_busy", 16'(busy), 16'd0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    base = oe_cnt;
    wr_byte(8'hE0, ack); check("t6_no_ack", 16'(ack), 16'd0);
    i2c_stop();
    tick(6);
    check("t6_no_oe", 16'(oe_cnt - base), 16'd0);

    check("wq_empty", 16'(wq.size()), 16'd0);
    check("rq_empty", 16'(rq.size()), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2c_regif.md
# i2c_regif

I2C target front-end for the dice design. It sits between the uio_in[2]/uio_in[3] SDA/SCL pads and the internal configuration/result register file. It decodes bus traffic addressed to its 7-bit device address into single-cycle register write strobes and read fetches, and drives SDA low for ACK and read data. It supports sub-address pointer, auto-increment and repeated start.

## Interface
- I2C_ADDR, 7'h70: 7-bit device address; the write address byte is 0xE0.
- clk  in  1  system clock; must be ≥ 16× the SCL frequency.
- rst_n  in  1  asynchronous active-low reset.
- sda_in  in  1  raw SDA (uio_in[2]).
- scl_in  in  1  raw SCL (uio_in[3]).
- sda_oe  out  1  1 = pull SDA low; drives uio_oe[2], with uio_out[2] tied 0.
- reg_addr  out  8  current sub-address pointer.
- wr_data  out  8  byte being written; valid while wr_en = 1.
- wr_en  out  1  one-cycle write strobe.
- rd_req  out  1  one-cycle fetch request for reg_addr.
- rd_data  in  8  register contents; valid the cycle after rd_req.
- busy  out  1  high from a START until the next STOP or return to IDLE.

## Operation
- **Input conditioning**
  - sda_in and scl_in each pass through a 2-FF synchronizer plus a third history flop.
  - All detection uses the synchronized signals:
    - rise = SCL 0→1.
    - fall = SCL 1→0.
    - START = SDA 1→0 while SCL = 1.
    - STOP = SDA 0→1 while SCL = 1.
- **Bit timing**
  - SDA is sampled on rise.
  - sda_oe changes only in the cycle after fall, so it never changes while SCL is high.
  - Bit counter counts 7..0; MSB first.
- **States:** IDLE, DEVADDR, DEVACK, SUBADDR, SUBACK, WDATA, WACK, RDATA, RACK, IGNORE.
- **Transitions**
  - START from any state → DEVADDR with bit counter reset. This also implements repeated start. The pointer is preserved.
  - STOP from any state → IDLE, sda_oe = 0.
  - DEVADDR: shift 8 bits.
    - Upper 7 bits == I2C_ADDR → DEVACK.
    - Otherwise → IGNORE, with no ACK (sda_oe stays 0).
  - DEVACK: sda_oe = 1 for the ninth clock. On the ninth fall:
    - R/W = 0 → SUBADDR.
    - R/W = 1 → RDATA, and rd_req pulses on that fall.
  - SUBADDR: after 8 bits, load reg_addr → SUBACK (ACK) → WDATA.
  - WDATA: after the 8th rise, pulse wr_en for one cycle with wr_data = received byte and reg_addr = pointer → WACK (ACK). On the ninth fall, reg_addr increments → WDATA.
  - RDATA
    - Shift register loads rd_data the cycle after rd_req.
    - Each bit: sda_oe = ~bit, set after fall.
    - After the 8th bit's fall, release SDA → RACK.
  - RACK: sample master ACK on rise.
    - ACK (SDA = 0): increment reg_addr, pulse rd_req at the ninth fall → RDATA.
    - NACK: → IGNORE.
  - IGNORE: sda_oe = 0; wait for START or STOP.
- **Arithmetic:** reg_addr is 8-bit modulo. 0xFF + 1 = 0x00.
- **Event priority:** START/STOP take priority over any bit event in the same cycle. wr_en and rd_req are never high together.

## Timing
- **Reset values:** state IDLE, sda_oe 0, reg_addr 0x00, wr_data 0x00, wr_en 0, rd_req 0, busy 0, shift register 0x00.
- **Reset mid-transaction:** immediate return to IDLE with SDA released. The next byte traffic is ignored until a fresh START.
- **Latency from bus edge to internal effect:** 3 clk cycles of synchronizer and edge detect.
  - wr_en asserts 1 cycle after the detected 8th rise.
  - rd_data is captured exactly 1 cycle after rd_req.
- **Write integrity:** a STOP or START before the 8th data bit discards the partial byte; no wr_en is produced.
- **ACK window:** sda_oe is held high from the fall after bit 0 until the ninth fall; it releases in the cycle after that fall.

## Test plan
- Write 0xE0, 0x0A, 0x55, 0x1F, STOP → ACK on all 4 bytes; wr_en at (0x0A, 0x55) then (0x0B, 0x1F); reg_addr = 0x0C after the final ACK.
- Write 0xE0, 0xFF, 0xFA, 0x4D → writes (0xFF, 0xFA) then (0x00, 0x4D); the pointer wraps.
- Read, with the regfile model returning addr ^ 0xA5:
  - Stimulus: 0xE0, 0x7E, repeated START, 0xE1; master ACKs byte 1 and NACKs byte 2; then STOP.
  - Required: bytes 0xDB then 0xDA appear on SDA, and rd_req pulses for 0x7E and 0x7F.
- Address 0xA0 → SDA never pulled low; no wr_en/rd_req until the next START; busy clears on STOP.
- STOP after 4 data bits of a write → no wr_en; state IDLE; a subsequent full write succeeds.
- rst_n low during a read while sda_oe = 1 → sda_oe = 0 and reg_addr = 0x00 immediately (asynchronous); all outputs at reset values.
